// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter: FSM state,
// circular winner search and one-hot encoding.
package rr_arb_pkg;

  localparam int unsigned MAX_N = 64;
  localparam int unsigned IDX_W = $clog2(MAX_N);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req in circular order ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
  // req is LSB-indexed: req[i] belongs to requester i.
  function automatic pick_t next_winner(input logic [MAX_N-1:0] req,
                                        input int unsigned      ptr,
                                        input int unsigned      n);
    pick_t       res;
    int unsigned pos;
    res = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        pos = ptr + k;
        if (pos >= n) pos = pos - n;
        if (!res.found && req[IDX_W'(pos)]) begin
          res.found = 1'b1;
          res.idx   = IDX_W'(pos);
        end
      end
    end
    return res;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input logic [IDX_W-1:0] index);
    logic [MAX_N-1:0] v;
    v        = '0;
    v[index] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_seq_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Vectors are [0:n-1]: bit 0 is requester 0 and is the leftmost bit.
interface rr_arbiter_seq_if #(
  parameter int unsigned n = 8
);
  localparam int unsigned IW = $clog2(n);

  logic [0:n-1]  r;
  logic [0:n-1]  g;
  logic [IW-1:0] gid;
  logic          busy;

  modport master (output r, input g, input gid, input busy);
  modport slave  (input r, output g, output gid, output busy);

endinterface

// File: rtl/rr_pick.sv
// Combinational circular priority picker; shared by fresh arbitration
// and owner handover.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter  int unsigned n  = 8,
  localparam int unsigned IW = $clog2(n)
) (
  input  logic [0:n-1]  r_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_c_o,
  output logic [IW-1:0] idx_c_o
);

  logic [MAX_N-1:0] req_flat;
  pick_t            pick;

  always_comb begin
    req_flat = '0;
    for (int unsigned i = 0; i < n; i++) begin
      req_flat[IDX_W'(i)] = r_i[IW'(i)];
    end
    pick      = next_winner(req_flat, 32'(ptr_i), n);
    found_c_o = pick.found;
    idx_c_o   = IW'(pick.idx);
  end

endmodule

// File: rtl/rr_arbiter_seq.sv
// Clocked round-robin arbiter with registered one-hot grants, release
// handover without bubbles and hold-time preemption.
module rr_arbiter_seq
  import rr_arb_pkg::*;
#(
  parameter int unsigned n        = 8,
  parameter int unsigned HOLD_MAX = 16
) (
  input logic             clock,
  input logic             reset,
  rr_arbiter_seq_if.slave bus
);

  localparam int unsigned   IW   = $clog2(n);
  localparam int unsigned   CW   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(n - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:n-1]  g_q, g_d;
  logic          busy_q, busy_d;

  logic [IW-1:0] next_owner;
  logic [IW-1:0] pick_ptr;
  logic [IW-1:0] win;
  logic          found;
  logic          others;
  logic          owner_req;
  logic          hand_off;
  logic [0:n-1]  win_g;

  // While busy, searching from owner+1 yields the handover winner directly;
  // the owner itself can only come out last, so win != owner means someone else waits.
  assign next_owner = (gid_q == LAST) ? '0 : gid_q + IW'(1);
  assign pick_ptr   = (state_q == BUSY) ? next_owner : ptr_q;

  rr_pick #(.n(n)) u_pick (
    .r_i       (bus.r),
    .ptr_i     (pick_ptr),
    .found_c_o (found),
    .idx_c_o   (win)
  );

  assign owner_req = bus.r[gid_q];
  assign others    = found && (win != gid_q);
  assign hand_off  = !owner_req ||
                     ((HOLD_MAX != 0) && (cnt_q == CW'(HOLD_MAX)) && others);

  always_comb begin
    for (int unsigned i = 0; i < n; i++) begin
      win_g[IW'(i)] = (win == IW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          g_d     = win_g;
          gid_d   = win;
          cnt_d   = CW'(1);
        end
      end
      BUSY: begin
        if (hand_off) begin
          ptr_d = next_owner;
          if (others) begin
            g_d   = win_g;
            gid_d = win;
            cnt_d = CW'(1);
          end else begin
            g_d     = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (cnt_q < CW'(HOLD_MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BUSY);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      g_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.g    = g_q;
  assign bus.gid  = gid_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_rr_arbiter_seq.sv
// Directed vector table plus hand-written reset/hold sequences and a
// randomized fairness soak for the round-robin arbiter.
module tb_rr_arbiter_seq;

  logic clk;
  logic rst;

  rr_arbiter_seq_if #(.n(4)) bus_a ();
  rr_arbiter_seq_if #(.n(4)) bus_z ();
  rr_arbiter_seq_if #(.n(8)) bus_s ();

  logic [0:3] pick_r;
  logic [1:0] pick_ptr;
  logic       pick_found;
  logic [1:0] pick_idx;

  rr_arbiter_seq #(.n(4), .HOLD_MAX(4)) u_a (.clock(clk), .reset(rst), .bus(bus_a));
  rr_arbiter_seq #(.n(4), .HOLD_MAX(0)) u_z (.clock(clk), .reset(rst), .bus(bus_z));
  rr_arbiter_seq #(.n(8), .HOLD_MAX(4)) u_s (.clock(clk), .reset(rst), .bus(bus_s));

  rr_pick #(.n(4)) u_pick (
    .r_i       (pick_r),
    .ptr_i     (pick_ptr),
    .found_c_o (pick_found),
    .idx_c_o   (pick_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [0:3] r;
    logic [0:3] g;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [0:3] r, input logic [0:3] g,
                              input logic [1:0] gid, input logic busy);
    vec_t v;
    v.r = r; v.g = g; v.gid = gid; v.busy = busy;
    return v;
  endfunction

  // Lowest index with a request, or -1: the plain fixed-priority reference.
  function automatic int fixed_prio(input logic [0:3] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  localparam int FAIR_BOUND = (8 - 1) * 4 + 8;

  initial begin
    logic [0:3] rot;
    logic [0:7] rs;
    int         wait_c [8];
    int         worst;
    int         exp_idx;

    rst = 1'b1;
    bus_a.r = '0; bus_z.r = '0; bus_s.r = '0;
    pick_r = '0; pick_ptr = '0;

    #2;
    check("reset_g",    32'(bus_a.g), 32'h0);
    check("reset_gid",  32'(bus_a.gid), 32'h0);
    check("reset_busy", 32'(bus_a.busy), 32'h0);
    check("reset_s_g",  32'(bus_s.g), 32'h0);

    // Picker against fixed priority at ptr=0 and against a rotated view elsewhere.
    for (int p = 0; p < 4; p++) begin
      for (int v = 0; v < 16; v++) begin
        pick_r = 4'(v); pick_ptr = 2'(p);
        #1;
        if (p == 0) begin
          exp_idx = fixed_prio(pick_r);
        end else begin
          for (int k = 0; k < 4; k++) rot[k] = pick_r[(p + k) % 4];
          exp_idx = fixed_prio(rot);
          if (exp_idx >= 0) exp_idx = (exp_idx + p) % 4;
        end
        check($sformatf("pick_found_p%0d_r%0h", p, v), 32'(pick_found), 32'(exp_idx >= 0));
        if (exp_idx >= 0)
          check($sformatf("pick_idx_p%0d_r%0h", p, v), 32'(pick_idx), 32'(exp_idx));
      end
    end

    // Rotation under preemption, release handover, wrap-around.
    for (int k = 0; k < 4; k++) vt.push_back(mk(4'b1111, 4'b1000, 2'd0, 1'b1));
    for (int k = 0; k < 4; k++) vt.push_back(mk(4'b1111, 4'b0100, 2'd1, 1'b1));
    for (int k = 0; k < 4; k++) vt.push_back(mk(4'b1111, 4'b0010, 2'd2, 1'b1));
    for (int k = 0; k < 4; k++) vt.push_back(mk(4'b1111, 4'b0001, 2'd3, 1'b1));
    vt.push_back(mk(4'b1111, 4'b1000, 2'd0, 1'b1));
    vt.push_back(mk(4'b1011, 4'b1000, 2'd0, 1'b1));
    vt.push_back(mk(4'b0011, 4'b0010, 2'd2, 1'b1));
    vt.push_back(mk(4'b0001, 4'b0001, 2'd3, 1'b1));
    vt.push_back(mk(4'b0000, 4'b0000, 2'd3, 1'b0));
    vt.push_back(mk(4'b0010, 4'b0010, 2'd2, 1'b1));
    vt.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b0));
    vt.push_back(mk(4'b1001, 4'b0001, 2'd3, 1'b1));
    vt.push_back(mk(4'b1000, 4'b1000, 2'd0, 1'b1));
    vt.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));

    @(negedge clk);
    rst = 1'b0;

    foreach (vt[k]) begin
      bus_a.r = vt[k].r;
      @(negedge clk);
      check($sformatf("vec%0d_g", k),    32'(bus_a.g),    32'(vt[k].g));
      check($sformatf("vec%0d_gid", k),  32'(bus_a.gid),  32'(vt[k].gid));
      check($sformatf("vec%0d_busy", k), 32'(bus_a.busy), 32'(vt[k].busy));
    end

    // Sole requester never preempted; HOLD_MAX=0 never preempts either.
    bus_a.r = 4'b0100;
    bus_z.r = 4'b0110;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("sole_g_%0d", k),   32'(bus_a.g),   32'(4'b0100));
      check($sformatf("sole_gid_%0d", k), 32'(bus_a.gid), 32'd1);
      check($sformatf("nopre_g_%0d", k),  32'(bus_z.g),   32'(4'b0100));
    end
    bus_a.r = '0; bus_z.r = '0;
    @(negedge clk);
    check("sole_release_busy", 32'(bus_a.busy), 32'h0);

    // Asynchronous reset mid-grant; first grant afterwards searches from 0.
    bus_a.r = 4'b0010;
    @(negedge clk);
    check("pre_rst_g", 32'(bus_a.g), 32'(4'b0010));
    #2 rst = 1'b1;
    #1;
    check("async_rst_g",    32'(bus_a.g), 32'h0);
    check("async_rst_busy", 32'(bus_a.busy), 32'h0);
    bus_a.r = 4'b0011;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_g",   32'(bus_a.g), 32'(4'b0010));
    check("post_rst_gid", 32'(bus_a.gid), 32'd2);
    bus_a.r = 4'b0001;
    @(negedge clk);
    check("post_rst_hand_g", 32'(bus_a.g), 32'(4'b0001));
    #2 rst = 1'b1;
    #1;
    check("pulse_rst_busy", 32'(bus_a.busy), 32'h0);
    #1 rst = 1'b0;
    bus_a.r = 4'b1001;
    @(negedge clk);
    check("ptr_cleared_g",   32'(bus_a.g), 32'(4'b1000));
    check("ptr_cleared_gid", 32'(bus_a.gid), 32'd0);
    bus_a.r = '0;

    // Soak: waiting requesters hold r until granted, owners drop at random.
    rs = '0;
    for (int i = 0; i < 8; i++) wait_c[i] = 0;
    bus_s.r = rs;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      check("soak_onehot", 32'($countones(bus_s.g) <= 1), 32'h1);
      check("soak_busy",   32'(bus_s.busy), 32'(|bus_s.g));
      check("soak_g_req",  32'(bus_s.g & ~bus_s.r), 32'h0);
      if (bus_s.busy) check("soak_gid", 32'(bus_s.g[bus_s.gid]), 32'h1);
      worst = 0;
      for (int i = 0; i < 8; i++) begin
        if (bus_s.r[i] && !bus_s.g[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > worst) worst = wait_c[i];
      end
      check("soak_fair", 32'(worst <= FAIR_BOUND), 32'h1);
      for (int i = 0; i < 8; i++) begin
        if (!rs[i])          rs[i] = ($urandom_range(3) == 0);
        else if (bus_s.g[i]) rs[i] = ($urandom_range(7) != 0);
      end
      bus_s.r = rs;
    end

    if (n_fail == 0) $display("No errors -- passed testbench");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
